// File: rtl/credential_gate_if.sv
// credential_gate_if: operator-side inputs and door-controller events of the credential gate
interface credential_gate_if #(
  parameter int CODE_W = 5
);
  logic [CODE_W-1:0] code_sw;
  logic              verify_btn;
  logic              clear_lock;
  logic              grant;
  logic              deny;
  logic              locked;
  logic [3:0]        fail_cnt;
  logic              busy;
  modport master (
    output code_sw, verify_btn, clear_lock,
    input  grant, deny, locked, fail_cnt, busy
  );
  modport slave (
    input  code_sw, verify_btn, clear_lock,
    output grant, deny, locked, fail_cnt, busy
  );
endinterface

// File: rtl/credential_gate.sv
// credential_gate: debounced code check issuing grant/deny pulses with failure count and timed lockout
module credential_gate #(
  parameter int                CODE_W      = 5,
  parameter logic [CODE_W-1:0] CODE        = CODE_W'(5'b11010),
  parameter int                DEB_CYCLES  = 500_000,
  parameter int                MAX_FAIL    = 3,
  parameter int                LOCK_CYCLES = 250_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  credential_gate_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CHECK, WAIT_REL, LOCKOUT} state_t;
  localparam logic [31:0] DEB_LAST  = 32'(DEB_CYCLES - 1);
  localparam logic [31:0] LOCK_LAST = 32'(LOCK_CYCLES - 1);
  localparam logic [3:0]  FAIL_MAX  = 4'(MAX_FAIL);
  state_t            state, state_d;
  logic [1:0]        btn_sync;
  logic [CODE_W-1:0] code_s1, code_s2, code_lat, code_d;
  logic              deb_lvl, verify_evt;
  logic [31:0]       deb_cnt, lock_cnt, lock_d;
  logic [3:0]        fail_cnt, fail_d;
  logic              grant, deny, grant_d, deny_d;
  // two-flop synchronizers for the asynchronous button and code switches
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      btn_sync <= '0;
      code_s1  <= '0;
      code_s2  <= '0;
    end else begin
      btn_sync <= {btn_sync[0], bus.verify_btn};
      code_s1  <= bus.code_sw;
      code_s2  <= code_s1;
    end
  // debounce: level follows the input only after DEB_CYCLES straight mismatching cycles; rising flip emits verify_evt
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      deb_cnt    <= '0;
      deb_lvl    <= 1'b0;
      verify_evt <= 1'b0;
    end else if (btn_sync[1] != deb_lvl && deb_cnt == DEB_LAST) begin
      deb_cnt    <= '0;
      deb_lvl    <= btn_sync[1];
      verify_evt <= btn_sync[1];
    end else begin
      deb_cnt    <= (btn_sync[1] != deb_lvl) ? deb_cnt + 32'd1 : '0;
      verify_evt <= 1'b0;
    end
  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      code_lat <= '0;
      fail_cnt <= '0;
      lock_cnt <= '0;
      grant    <= 1'b0;
      deny     <= 1'b0;
    end else begin
      state    <= state_d;
      code_lat <= code_d;
      fail_cnt <= fail_d;
      lock_cnt <= lock_d;
      grant    <= grant_d;
      deny     <= deny_d;
    end
  // next state: a CHECK verdict overrides a concurrent supervisor clear
  always_comb begin
    state_d = state;
    code_d  = code_lat;
    fail_d  = bus.clear_lock ? '0 : fail_cnt;
    lock_d  = '0;
    grant_d = 1'b0;
    deny_d  = 1'b0;
    case (state)
      IDLE: if (verify_evt) begin
        code_d  = code_s2;
        state_d = CHECK;
      end
      CHECK: begin
        grant_d = code_lat == CODE;
        deny_d  = code_lat != CODE;
        fail_d  = grant_d ? '0 : fail_cnt + 4'd1;
        state_d = (deny_d && fail_cnt + 4'd1 == FAIL_MAX) ? LOCKOUT : WAIT_REL;
      end
      WAIT_REL: if (!deb_lvl) state_d = IDLE;
      LOCKOUT: begin
        lock_d = lock_cnt + 32'd1;
        if (bus.clear_lock || lock_cnt == LOCK_LAST) begin
          lock_d  = '0;
          fail_d  = '0;
          state_d = WAIT_REL;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.grant    = grant;
  assign bus.deny     = deny;
  assign bus.locked   = state == LOCKOUT;
  assign bus.fail_cnt = fail_cnt;
  assign bus.busy     = state != IDLE;
endmodule

// File: tb/tb_credential_gate.sv
// tb_credential_gate: directed press scenarios checked every cycle against an event-level model
module tb_credential_gate;
  localparam int DEB = 4, LOCK = 20, MAXF = 3;
  localparam logic [4:0] CODE = 5'b11010;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  credential_gate_if #(.CODE_W(5)) bus ();
  credential_gate #(.CODE_W(5), .CODE(CODE), .DEB_CYCLES(DEB), .MAX_FAIL(MAXF), .LOCK_CYCLES(LOCK)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  int checks = 0, errors = 0, tcyc = 0, n_grant = 0, n_deny = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, tcyc);
    end
  endtask
  // model: raw button seen two edges late; debounced level needs DEB straight disagreeing samples;
  // an accepted press gets its verdict two edges after the debounced rise; lockout lasts LOCK cycles
  logic [1:0] bp = '0;
  logic [4:0] cp0 = '0, cp1 = '0, m_code = '0;
  logic m_lvl = 0, m_evt = 0, m_eng = 0, m_chk = 0, e_grant = 0, e_deny = 0, idle_old = 0, rel = 0;
  int m_run = 0, m_lock = 0, e_fail = 0;
  // reference model stepped on each clock edge
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bp = '0; cp0 = '0; cp1 = '0; m_code = '0;
      m_lvl = 0; m_evt = 0; m_eng = 0; m_chk = 0; e_grant = 0; e_deny = 0;
      m_run = 0; m_lock = 0; e_fail = 0;
    end else begin
      idle_old = !m_eng;
      rel = m_eng && !m_chk && m_lock == 0 && !m_lvl;
      e_grant = 0;
      e_deny = 0;
      if (m_lock > 0) begin
        if (bus.clear_lock || m_lock == 1) begin m_lock = 0; e_fail = 0; end
        else m_lock--;
      end else if (m_chk) begin
        m_chk = 0;
        if (m_code == CODE) begin e_grant = 1; e_fail = 0; end
        else begin
          e_deny = 1;
          e_fail++;
          if (e_fail == MAXF) m_lock = LOCK;
        end
      end else if (bus.clear_lock) e_fail = 0;
      if (rel) m_eng = 0;
      if (m_evt && idle_old) begin m_eng = 1; m_chk = 1; m_code = cp1; end
      m_evt = 0;
      if (bp[1] != m_lvl) begin
        m_run++;
        if (m_run == DEB) begin m_lvl = bp[1]; m_run = 0; m_evt = m_lvl; end
      end else m_run = 0;
      bp = {bp[0], bus.verify_btn};
      cp1 = cp0;
      cp0 = bus.code_sw;
    end
  // cycle counter
  always @(posedge clk) tcyc++;
  // compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    chk("grant", bus.grant, e_grant);
    chk("deny", bus.deny, e_deny);
    chk("locked", bus.locked, m_lock > 0);
    chk("fail_cnt", bus.fail_cnt, e_fail);
    chk("busy", bus.busy, m_eng);
    if (bus.grant) n_grant++;
    if (bus.deny) n_deny++;
  end
  task automatic step(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask
  task automatic wait_verdict(output int lat, output int kind);
    int t0;
    t0 = tcyc;
    lat = -1;
    kind = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.grant || bus.deny) begin
        lat = tcyc - t0;
        kind = bus.grant ? 1 : 2;
        break;
      end
    end
  endtask
  task automatic do_fails(input int n, output int r);
    int lat, kind;
    r = 0;
    for (int k = 1; k <= n; k++) begin
      bus.verify_btn = 1;
      wait_verdict(lat, kind);
      chk("fail_lat", lat, 8);
      chk("fail_kind", kind, 2);
      chk("fail_cnt_step", bus.fail_cnt, k);
      chk("lock_with_deny", bus.locked, k == MAXF);
      r = tcyc;
      bus.verify_btn = 0;
      if (k < n) step(10);
    end
  endtask
  initial begin
    int lat, kind, g0, r;
    bus.code_sw = '0; bus.verify_btn = 0; bus.clear_lock = 0;
    step(3);
    chk("rst_grant", bus.grant, 0); chk("rst_deny", bus.deny, 0); chk("rst_locked", bus.locked, 0);
    chk("rst_fail", bus.fail_cnt, 0); chk("rst_busy", bus.busy, 0);
    rst_n = 1;
    step(3);
    bus.code_sw = CODE;
    step(3);
    bus.verify_btn = 1;
    wait_verdict(lat, kind);
    chk("t1_lat", lat, 8); chk("t1_kind", kind, 1); chk("t1_busy", bus.busy, 1);
    step(10);
    bus.verify_btn = 0;
    step(10);
    chk("t1_grants", n_grant, 1); chk("t1_denies", n_deny, 0);
    chk("t1_fail", bus.fail_cnt, 0); chk("t1_busy_after", bus.busy, 0);
    g0 = n_grant;
    for (int i = 0; i < 12; i++) begin bus.verify_btn = (i % 4) < 2; step(); end
    bus.verify_btn = 1;
    wait_verdict(lat, kind);
    chk("t2_lat", lat, 8); chk("t2_kind", kind, 1);
    step(4);
    bus.verify_btn = 0;
    step(10);
    chk("t2_grants", n_grant, g0 + 1);
    bus.code_sw = '0;
    step(3);
    do_fails(3, r);
    g0 = n_grant;
    bus.code_sw = CODE;
    step(8);
    bus.verify_btn = 1;
    step(6);
    bus.verify_btn = 0;
    step(r + 19 - tcyc);
    chk("t4_locked_last", bus.locked, 1);
    step();
    chk("t4_unlocked", bus.locked, 0); chk("t4_fail", bus.fail_cnt, 0); chk("t4_no_grant", n_grant, g0);
    step(5);
    bus.verify_btn = 1;
    wait_verdict(lat, kind);
    chk("t4_lat", lat, 8); chk("t4_kind", kind, 1);
    bus.verify_btn = 0;
    step(10);
    chk("t4_grants", n_grant, g0 + 1);
    bus.code_sw = '0;
    step(3);
    do_fails(3, r);
    step(5);
    chk("t5_locked_c5", bus.locked, 1);
    bus.clear_lock = 1;
    step();
    bus.clear_lock = 0;
    chk("t5_cleared", bus.locked, 0); chk("t5_fail", bus.fail_cnt, 0);
    step(10);
    do_fails(2, r);
    step(10);
    chk("t5b_fail2", bus.fail_cnt, 2);
    bus.clear_lock = 1;
    step();
    bus.clear_lock = 0;
    chk("t5b_fail0", bus.fail_cnt, 0);
    bus.code_sw = CODE;
    step(3);
    g0 = n_grant;
    bus.verify_btn = 1;
    step(7);
    chk("t6_busy_check", bus.busy, 1);
    rst_n = 0;
    bus.verify_btn = 0;
    #1;
    chk("t6_grant", bus.grant, 0); chk("t6_deny", bus.deny, 0); chk("t6_locked", bus.locked, 0);
    chk("t6_fail", bus.fail_cnt, 0); chk("t6_busy", bus.busy, 0);
    step(2);
    rst_n = 1;
    step(15);
    chk("t6_no_grant", n_grant, g0); chk("t6_idle", bus.busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  // watchdog against a hung run
  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit at cycle %0d", tcyc);
    $fatal(1, "timeout");
  end
endmodule
